// File: rtl/bldc_pkg.sv
// Shared types and the Hall commutation table for the BLDC sequencer.
// COMM_REVERSE_EN (see bldc_comm_seq) uses the rev argument of comm_lut.
package bldc_pkg;

    localparam int DUTY_W = 11;

    typedef enum logic [1:0] {
        COAST = 2'b00,
        REV   = 2'b01,
        FWD   = 2'b10,
        BRK   = 2'b11
    } coil_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BRAKE,
        STALL
    } state_t;

    typedef struct packed {
        coil_sel_t g;
        coil_sel_t y;
        coil_sel_t b;
    } coil_t;

    function automatic coil_sel_t flip(input coil_sel_t s);
        return (s == FWD) ? REV : (s == REV) ? FWD : s;
    endfunction

    function automatic logic hall_bad(input logic [2:0] h);
        return (h == 3'b000) || (h == 3'b111);
    endfunction

    function automatic coil_t comm_lut(input logic [2:0] h,
                                       input logic       rev);
        coil_t c;
        case (h)
            3'b101:  c = '{FWD,   REV,   COAST};
            3'b100:  c = '{FWD,   COAST, REV};
            3'b110:  c = '{COAST, FWD,   REV};
            3'b010:  c = '{REV,   FWD,   COAST};
            3'b011:  c = '{REV,   COAST, FWD};
            3'b001:  c = '{COAST, REV,   FWD};
            default: c = '{COAST, COAST, COAST};
        endcase
        if (rev) begin
            c = '{flip(c.g), flip(c.y), flip(c.b)};
        end
        return c;
    endfunction

endpackage

// File: rtl/duty_ramp.sv
// Slew-limited duty register; steps toward i_target once per i_en,
// or jumps straight to i_load_val when i_load is set.
module duty_ramp
    import bldc_pkg::*;
#(
    parameter int RAMP_STEP = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_load,
    input  logic [DUTY_W-1:0] i_load_val,
    input  logic [DUTY_W-1:0] i_target,
    output logic [DUTY_W-1:0] o_duty,
    output logic              o_at_target
);

    localparam logic [DUTY_W-1:0] STEP = DUTY_W'(RAMP_STEP);

    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] w_diff;
    logic [DUTY_W-1:0] w_next;
    logic              w_up;

    always_comb begin
        w_up   = i_target > r_duty;
        w_diff = w_up ? (i_target - r_duty) : (r_duty - i_target);
        if (w_diff > STEP) begin
            w_diff = STEP;
        end
        w_next = w_up ? (r_duty + w_diff) : (r_duty - w_diff);
        if (i_load) begin
            w_next = i_load_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty <= '0;
        end else if (i_en) begin
            r_duty <= w_next;
        end
    end

    assign o_duty      = r_duty;
    assign o_at_target = (r_duty == i_target);

endmodule

// File: rtl/bldc_comm_seq.sv
// BLDC commutation/duty sequencer, all updates aligned to PWM_synch.
// Define COMM_REVERSE_EN to add the dir input (reversal via zero duty).
module bldc_comm_seq
    import bldc_pkg::*;
#(
    parameter int                RAMP_STEP = 8,
    parameter int                STALL_CNT = 2000,
    parameter logic [DUTY_W-1:0] BRK_DUTY  = 11'h600
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hallGrn,
    input  logic              hallYlw,
    input  logic              hallBlu,
    input  logic [DUTY_W-1:0] drv_mag,
    input  logic              brake_n,
    input  logic              PWM_synch,
`ifdef COMM_REVERSE_EN
    input  logic              dir,
`endif
    output logic [1:0]        selGrn,
    output logic [1:0]        selYlw,
    output logic [1:0]        selBlu,
    output logic [DUTY_W-1:0] duty,
    output logic              stall,
    output logic              hall_err
);

    localparam int            CW      = $clog2(STALL_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STALL_CNT);

    logic [2:0]        r_hs1, r_hs2, r_hall_q;
    state_t            r_state, w_next;
    coil_t             r_sel, w_sel;
    logic [CW-1:0]     r_cnt, w_cnt;
    logic              r_stall, r_hall_err;
    logic              w_edge, w_load, w_at_tgt, w_rev;
    logic [DUTY_W-1:0] w_duty, w_tgt, w_load_val;

`ifdef COMM_REVERSE_EN
    logic r_dir;
    // a direction change in RUN waits until duty has ramped to zero
    assign w_rev = (r_state != RUN || w_duty == '0) ? dir : r_dir;
    assign w_tgt = (r_state == RUN && dir != r_dir) ? '0 : drv_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir <= 1'b0;
        end else if (PWM_synch) begin
            r_dir <= w_rev;
        end
    end
`else
    assign w_rev = 1'b0;
    assign w_tgt = drv_mag;
`endif

    assign w_edge = (r_hs2 != r_hall_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs1    <= '0;
            r_hs2    <= '0;
            r_hall_q <= '0;
        end else begin
            r_hs1 <= {hallGrn, hallYlw, hallBlu};
            r_hs2 <= r_hs1;
            if (PWM_synch) begin
                r_hall_q <= r_hs2;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt      = '0;
        w_sel      = '{COAST, COAST, COAST};
        w_load     = 1'b1;
        w_load_val = '0;
        unique case (r_state)
            IDLE: begin
                if (!brake_n) w_next = BRAKE;
                else if (drv_mag != '0) w_next = RUN;
            end
            RUN: begin
                w_cnt = r_cnt;
                if (w_edge || w_duty == '0) w_cnt = '0;
                else if (r_cnt != CNT_MAX) w_cnt = r_cnt + 1'b1;
                if (!brake_n) w_next = BRAKE;
                else if (w_cnt == CNT_MAX) w_next = STALL;
                else if (drv_mag == '0 && w_at_tgt) w_next = IDLE;
            end
            BRAKE: begin
                if (brake_n) w_next = IDLE;
            end
            STALL: begin
                if (drv_mag == '0) w_next = IDLE;
            end
        endcase
        if (w_next != RUN) w_cnt = '0;
        unique case (w_next)
            RUN: begin
                w_sel  = comm_lut(r_hs2, w_rev);
                w_load = 1'b0;
            end
            BRAKE: begin
                w_sel      = '{BRK, BRK, BRK};
                w_load_val = BRK_DUTY;
            end
            IDLE, STALL: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_sel      <= '{COAST, COAST, COAST};
            r_stall    <= 1'b0;
            r_hall_err <= 1'b0;
        end else if (PWM_synch) begin
            r_state    <= w_next;
            r_cnt      <= w_cnt;
            r_sel      <= w_sel;
            r_stall    <= (w_next == STALL);
            r_hall_err <= hall_bad(r_hs2);
        end
    end

    duty_ramp #(
        .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (PWM_synch),
        .i_load      (w_load),
        .i_load_val  (w_load_val),
        .i_target    (w_tgt),
        .o_duty      (w_duty),
        .o_at_target (w_at_tgt)
    );

    assign selGrn   = r_sel.g;
    assign selYlw   = r_sel.y;
    assign selBlu   = r_sel.b;
    assign duty     = w_duty;
    assign stall    = r_stall;
    assign hall_err = r_hall_err;

endmodule

// File: doc/bldc_comm_seq.md
Name: bldc_comm_seq

Overview:
- Commutation and duty sequencer that sits directly upstream of the motor-drive block (PWM plus three nonoverlap half-bridges).
- Reads three Hall sensors and generates the per-coil selGrn/selYlw/selBlu codes.
- Soft-ramps the 11-bit duty toward a requested magnitude; handles braking and stall detection.
- All updates are aligned to the driver's PWM_synch pulse, so coil and duty changes land on PWM period boundaries.

Parameters:
RAMP_STEP, 8, maximum duty change (LSBs) per PWM_synch pulse
STALL_CNT, 2000, PWM_synch pulses without a Hall edge in RUN before stall is declared
BRK_DUTY, 11'h600, duty driven while braking

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
hallGrn  input  1  Hall sensor, green phase; asynchronous
hallYlw  input  1  Hall sensor, yellow phase; asynchronous
hallBlu  input  1  Hall sensor, blue phase; asynchronous
drv_mag  input  11  requested duty magnitude; 0 = stop
brake_n  input  1  active-low brake request; level
PWM_synch  input  1  one-clock pulse per PWM period, from the motor driver
selGrn  output  2  green coil select: 00 coast, 01 reverse, 10 forward, 11 brake
selYlw  output  2  yellow coil select, same encoding
selBlu  output  2  blue coil select, same encoding
duty  output  11  duty to the motor driver
stall  output  1  sticky stall flag
hall_err  output  1  registered; current Hall code is 000 or 111

Behaviour:
- Reset is asynchronous and active-low on rst_n; the block uses the single clock clk.
- Reset values: state=IDLE, sel*=00, duty=0, stall=0, hall_err=0. The Hall synchronisers reset to 0, and the stall counter resets to 0.
- Hall path:
  - Each Hall input passes through a 2-flop synchroniser.
  - The synchronised code {G,Y,B} is captured into hall_q only on a PWM_synch cycle.
  - A Hall edge means the new hall_q differs from the previous hall_q.
- Commutation table, indexed by hall_q and giving G/Y/B selects:
  - 101 -> 10/01/00
  - 100 -> 10/00/01
  - 110 -> 00/10/01
  - 010 -> 01/10/00
  - 011 -> 01/00/10
  - 001 -> 00/01/10
  - 000 or 111 -> all 00, and hall_err=1.
- The sel* and duty outputs are registered and update only in the clock after a PWM_synch. Latency from PWM_synch to output change is 1 clk.
- FSM transitions:
  - IDLE: sel*=00, duty=0. Go to BRAKE if !brake_n; otherwise go to RUN if drv_mag!=0.
  - RUN: sel* follow the table. On each PWM_synch, duty moves toward target=drv_mag by min(|target-duty|, RAMP_STEP); it never overshoots and never wraps.
    - Go to BRAKE if !brake_n.
    - Go to IDLE when drv_mag==0 and duty==0.
    - Go to STALL when the counter reaches STALL_CNT.
  - BRAKE: sel*=11, duty=BRK_DUTY immediately (no ramp). Go to IDLE when brake_n=1; duty restarts from 0.
  - STALL: sel*=00, duty=0, stall=1. Go to IDLE only when drv_mag==0. stall clears on that exit.
- Priority per cycle: brake > stall > ramp/commutate.
- Stall counter:
  - Counts PWM_synch pulses in RUN while duty!=0.
  - Clears on any Hall edge, on leaving RUN, and while duty==0.
  - Saturates at STALL_CNT.
- hall_err in RUN forces sel*=00 for that period but does not change state. duty keeps ramping.
- An async reset mid-ramp or mid-brake returns all outputs to their reset values immediately.

Optional Feature:
- Macro: COMM_REVERSE_EN.
- When defined: adds input port dir (1 bit). While dir=1, the table swaps 01<->10 on every phase; 00 and 11 are unchanged. dir is sampled only on PWM_synch.
- A dir change while duty!=0 ramps duty to 0 first, then applies the new direction, then ramps back up.
- When not defined: the dir port is absent and operation is forward-only.

Decomposition:
- Package bldc_pkg holds:
  - typedef enum logic[1:0] coil_sel_t {COAST=00, REV=01, FWD=10, BRK=11}
  - FSM state enum {IDLE, RUN, BRAKE, STALL}
  - DUTY_W=11
- Sub-module duty_ramp: registered duty, target, step, and enable on PWM_synch; outputs duty and at_target.
- The commutation table is a combinational function in the package.

Test Plan:
- Reset, then drv_mag=0x400 with PWM_synch every 2048 clks -> duty rises by 8 per pulse and reaches 0x400 after 128 pulses; no overshoot.
- In RUN, step the Hall inputs through 101,100,110,010,011,001 -> sel* match the table one clk after the next PWM_synch, never mid-period.
- Hold the Hall inputs constant with duty>0 for 2000 PWM_synch -> stall=1, sel*=00, duty=0. Setting drv_mag=0 -> IDLE and stall=0.
- Pull brake_n low during a ramp at duty=0x100 -> next PWM_synch gives sel*=11, duty=0x600. Releasing brake_n -> IDLE, duty=0, then a new ramp from 0.
- Drive Hall=111 in RUN -> hall_err=1, sel*=00, state stays RUN. Returning Hall to 101 -> table selects restored.
- COMM_REVERSE_EN defined, Hall=101, dir 0->1 at duty=0x40 -> duty ramps to 0, then selects become 01/10/00, then duty ramps back to drv_mag.
